// File: rtl/alu_result_stage_if.sv
// Handshake/bus bundle between the ALU, the result stage and its consumer.
// The stage uses the slave view; the ALU/consumer side uses the master view.
interface alu_result_stage_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic [2:0]       SEL;
    logic             A_MSB;
    logic             B_MSB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic [3:0]       FLAGS;
    logic [2:0]       OP;
    logic [CW-1:0]    COUNT;

    modport slave (
        input  IN_VALID, SUM, COUT, SEL, A_MSB, B_MSB, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, FLAGS, OP, COUNT
    );

    modport master (
        output IN_VALID, SUM, COUT, SEL, A_MSB, B_MSB, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, FLAGS, OP, COUNT
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result/flag stage with an in-order FIFO of DEPTH entries.
// Optional sticky-overflow tracking is enabled by defining ALU_RES_STICKY_EN.
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    alu_result_stage_if.slave   bus
`ifdef ALU_RES_STICKY_EN
    ,
    input  logic                CLR_STICKY,
    output logic                STICKY_V
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Flags are fixed at capture time so the head never depends on live ALU inputs.
    function automatic logic [3:0] derive_flags(
        input logic [WIDTH-1:0] sum,
        input logic             cout,
        input logic [2:0]       sel,
        input logic             a_msb,
        input logic             b_msb
    );
        logic s, n, z, c, v;
        s = sum[WIDTH-1];
        n = s;
        z = (sum == '0);
        c = sel[2] ? 1'b0 : cout;
        case (sel)
            3'b000:  v = (a_msb == b_msb) & (s != a_msb);
            3'b001:  v = ~a_msb & s;
            3'b010:  v = (a_msb != b_msb) & (s != a_msb);
            3'b011:  v = a_msb & ~s;
            default: v = 1'b0;
        endcase
        return {n, z, c, v};
    endfunction

    logic [WIDTH-1:0] res_q  [DEPTH];
    logic [3:0]       flg_q  [DEPTH];
    logic [2:0]       op_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic empty, push, pop;

    assign empty        = (count_q == '0);
    assign bus.IN_READY = ~RST & (count_q < FULL);
    assign bus.OUT_VALID = ~empty;
    assign push         = bus.IN_VALID & bus.IN_READY;
    assign pop          = ~empty & bus.OUT_READY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds data only; stale contents are masked by the empty check.
    always_ff @(posedge CLK) begin
        if (push) begin
            res_q[wr_ptr_q] <= bus.SUM;
            flg_q[wr_ptr_q] <= derive_flags(bus.SUM, bus.COUT, bus.SEL, bus.A_MSB, bus.B_MSB);
            op_q[wr_ptr_q]  <= bus.SEL;
        end
    end

    assign bus.RESULT = empty ? '0 : res_q[rd_ptr_q];
    assign bus.FLAGS  = empty ? '0 : flg_q[rd_ptr_q];
    assign bus.OP     = empty ? '0 : op_q[rd_ptr_q];
    assign bus.COUNT  = count_q;

`ifdef ALU_RES_STICKY_EN
    logic sticky_q;

    // A V=1 pop takes priority over a coincident clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sticky_q <= 1'b0;
        end else if (pop && flg_q[rd_ptr_q][0]) begin
            sticky_q <= 1'b1;
        end else if (CLR_STICKY) begin
            sticky_q <= 1'b0;
        end
    end

    assign STICKY_V = sticky_q;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a randomized
// run checked against a queue-based reference model of the ALU and FIFO.
module tb_alu_result_stage;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    alu_result_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef ALU_RES_STICKY_EN
    logic CLR_STICKY;
    logic STICKY_V;
`endif

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus)
`ifdef ALU_RES_STICKY_EN
        ,
        .CLR_STICKY (CLR_STICKY),
        .STICKY_V   (STICKY_V)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] sum, input logic cout,
                         input logic [2:0] sel, input logic a, input logic b);
        bus.IN_VALID = v;
        bus.SUM      = sum;
        bus.COUT     = cout;
        bus.SEL      = sel;
        bus.A_MSB    = a;
        bus.B_MSB    = b;
    endtask

    // Reference ALU: operands in, sum/carry and expected flags out, using signed integer range checks.
    task automatic alu_ref(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                           input logic stale_c, output logic [15:0] sum, output logic cout,
                           output logic [3:0] flags);
        logic [16:0] full;
        int sa, sb, sr;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        sr = 0;
        full = '0;
        case (sel)
            3'd0: begin full = {1'b0, a} + {1'b0, b};      sr = sa + sb; end
            3'd1: begin full = {1'b0, a} + 17'd1;          sr = sa + 1;  end
            3'd2: begin full = {1'b0, a} + {1'b0, ~b} + 17'd1; sr = sa - sb; end
            3'd3: begin full = {1'b0, a} + 17'h0FFFF;      sr = sa - 1;  end
            3'd4: full = {stale_c, a & b};
            3'd5: full = {stale_c, a | b};
            3'd6: full = {stale_c, a ^ b};
            default: full = {stale_c, ~a};
        endcase
        sum  = full[15:0];
        cout = full[16];
        v = (sel < 3'd4) && (sr > 32767 || sr < -32768);
        flags = {sum[15], sum == 16'h0, (sel < 3'd4) ? cout : 1'b0, v};
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        n_checks++; if (bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", bus.IN_READY); end
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", bus.COUNT); end
        n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", bus.OUT_VALID); end
        n_checks++; if ({bus.RESULT, bus.FLAGS, bus.OP} !== 23'h0) begin n_fail++; $display("FAIL rst_outputs got %h/%b/%b want 0", bus.RESULT, bus.FLAGS, bus.OP); end
        tick();
        RST = 1'b0;
        #1;
        n_checks++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %0b want 1", bus.IN_READY); end
        drive(1'b1, 16'h1111, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h2222, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h9999, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.COUNT !== 2'd2) begin n_fail++; $display("FAIL pre_rst_count got %0d want 2", bus.COUNT); end
        RST = 1'b1;
        #1;
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL async_rst_count got %0d want 0", bus.COUNT); end
        n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %0b want 0", bus.OUT_VALID); end
        n_checks++; if (bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready got %0b want 0", bus.IN_READY); end
        n_checks++; if (bus.RESULT !== 16'h0) begin n_fail++; $display("FAIL async_rst_result got %h want 0", bus.RESULT); end
        tick();
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL rst_edge_push got %0d want 0", bus.COUNT); end
        RST = 1'b0;
        drive(1'b1, 16'h3333, 1'b0, 3'b000, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0b want 1", bus.IN_READY); end
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.RESULT !== 16'h3333 || bus.COUNT !== 2'd1) begin n_fail++; $display("FAIL post_rst_data got %h/%0d want 3333/1", bus.RESULT, bus.COUNT); end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL post_rst_drain got %0d want 0", bus.COUNT); end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL add_no_bypass got %0b want 0", bus.OUT_VALID); end
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0b want 1", bus.OUT_VALID); end
        n_checks++; if (bus.RESULT !== 16'h8000) begin n_fail++; $display("FAIL add_result got %h want 8000", bus.RESULT); end
        n_checks++; if (bus.FLAGS !== 4'b1001) begin n_fail++; $display("FAIL add_flags got %b want 1001", bus.FLAGS); end
        n_checks++; if (bus.OP !== 3'b000) begin n_fail++; $display("FAIL add_op got %b want 000", bus.OP); end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_logic_flags();
        drive(1'b1, 16'h0000, 1'b1, 3'b111, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.FLAGS !== 4'b0100) begin n_fail++; $display("FAIL logic_flags got %b want 0100", bus.FLAGS); end
        n_checks++; if (bus.OP !== 3'b111) begin n_fail++; $display("FAIL logic_op got %b want 111", bus.OP); end
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        n_checks++; if (bus.OUT_VALID !== 1'b0 || bus.FLAGS !== 4'b0000) begin n_fail++; $display("FAIL empty_zero got %0b/%b want 0/0000", bus.OUT_VALID, bus.FLAGS); end
    endtask

    task automatic test_full_backpressure();
        logic [15:0] got [$];
        bus.OUT_READY = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0003, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.IN_READY !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", bus.IN_READY); end
        n_checks++; if (bus.COUNT !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", bus.COUNT); end
        tick();
        n_checks++; if (bus.COUNT !== 2'd2 || bus.RESULT !== 16'h0001) begin n_fail++; $display("FAIL full_hold got %0d/%h want 2/0001", bus.COUNT, bus.RESULT); end
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 6 && got.size() < 3; i++) begin
            if (bus.OUT_VALID) got.push_back(bus.RESULT);
            if (got.size() == 2) bus.IN_VALID = 1'b1;
            tick();
            if (bus.IN_VALID && bus.COUNT != 2'd2 && got.size() >= 2) bus.IN_VALID = 1'b0;
        end
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL order_len got %0d want 3", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL order_%0d got %h want %h", i, got[i], 16'(i + 1)); end
        end
        if (bus.COUNT != 2'd0) begin
            bus.OUT_READY = 1'b1;
            tick();
            tick();
            bus.OUT_READY = 1'b0;
        end
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL order_drain got %0d want 0", bus.COUNT); end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 16'h00AA, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00BB, 1'b0, 3'b000, 1'b0, 1'b0);
        bus.OUT_READY = 1'b1;
        n_checks++; if (bus.RESULT !== 16'h00AA) begin n_fail++; $display("FAIL simul_head got %h want 00AA", bus.RESULT); end
        tick();
        n_checks++; if (bus.COUNT !== 2'd1 || bus.RESULT !== 16'h00BB) begin n_fail++; $display("FAIL simul_swap got %0d/%h want 1/00BB", bus.COUNT, bus.RESULT); end
        drive(1'b1, 16'h0000, 1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (bus.COUNT !== 2'd1 || bus.FLAGS !== 4'b0110) begin n_fail++; $display("FAIL sub_flags got %0d/%b want 1/0110", bus.COUNT, bus.FLAGS); end
        tick();
        bus.OUT_READY = 1'b0;
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL simul_drain got %0d want 0", bus.COUNT); end
    endtask

    task automatic test_random();
        logic [15:0] q_res [$];
        logic [3:0]  q_flg [$];
        logic [2:0]  q_op  [$];
        logic [15:0] a, b, sum;
        logic [2:0]  sel;
        logic        v, cout, stale, hold, ready, push, pop;
        logic [3:0]  flg;
        hold = 1'b0;
        v = 1'b0; sel = '0; a = '0; b = '0; sum = '0; cout = 1'b0; flg = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                v     = ($urandom_range(0, 3) != 0);
                sel   = 3'($urandom_range(0, 7));
                a     = 16'($urandom);
                b     = 16'($urandom);
                if (cyc % 7 == 0) a = 16'h7FFF;
                if (cyc % 11 == 0) a = 16'h8000;
                stale = 1'($urandom);
                alu_ref(sel, a, b, stale, sum, cout, flg);
            end
            drive(v, sum, cout, sel, a[15], b[15]);
            bus.OUT_READY = ($urandom_range(0, 2) != 0);
            #1;
            ready = (q_res.size() < DEPTH);
            n_checks++; if (bus.IN_READY !== ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, bus.IN_READY, ready); end
            n_checks++; if (bus.COUNT !== 2'(q_res.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, bus.COUNT, q_res.size()); end
            if (q_res.size() > 0) begin
                n_checks++; if ({bus.OUT_VALID, bus.RESULT, bus.FLAGS, bus.OP} !== {1'b1, q_res[0], q_flg[0], q_op[0]}) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d got %0b/%h/%b/%b want 1/%h/%b/%b", cyc, bus.OUT_VALID, bus.RESULT, bus.FLAGS, bus.OP, q_res[0], q_flg[0], q_op[0]);
                end
            end else begin
                n_checks++; if ({bus.OUT_VALID, bus.RESULT, bus.FLAGS, bus.OP} !== 24'h0) begin
                    n_fail++; $display("FAIL rnd_empty cyc %0d got %0b/%h/%b/%b want zeros", cyc, bus.OUT_VALID, bus.RESULT, bus.FLAGS, bus.OP);
                end
            end
            push = v && ready;
            pop  = (q_res.size() > 0) && bus.OUT_READY;
            tick();
            if (pop) begin
                void'(q_res.pop_front()); void'(q_flg.pop_front()); void'(q_op.pop_front());
            end
            if (push) begin
                q_res.push_back(sum); q_flg.push_back(flg); q_op.push_back(sel);
            end
            hold = v && !ready;
        end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        bus.OUT_READY = 1'b1;
        tick();
        tick();
        bus.OUT_READY = 1'b0;
        n_checks++; if (bus.COUNT !== 2'd0) begin n_fail++; $display("FAIL rnd_drain got %0d want 0", bus.COUNT); end
    endtask

`ifdef ALU_RES_STICKY_EN
    task automatic test_sticky();
        CLR_STICKY = 1'b1;
        tick();
        CLR_STICKY = 1'b0;
        n_checks++; if (STICKY_V !== 1'b0) begin n_fail++; $display("FAIL sticky_init got %0b want 0", STICKY_V); end
        drive(1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        n_checks++; if (STICKY_V !== 1'b0) begin n_fail++; $display("FAIL sticky_no_pop got %0b want 0", STICKY_V); end
        bus.OUT_READY = 1'b1;
        tick();
        n_checks++; if (STICKY_V !== 1'b1) begin n_fail++; $display("FAIL sticky_set got %0b want 1", STICKY_V); end
        drive(1'b1, 16'h0005, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        n_checks++; if (STICKY_V !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got %0b want 1", STICKY_V); end
        CLR_STICKY = 1'b1;
        tick();
        CLR_STICKY = 1'b0;
        n_checks++; if (STICKY_V !== 1'b0) begin n_fail++; $display("FAIL sticky_clr got %0b want 0", STICKY_V); end
        bus.OUT_READY = 1'b0;
        drive(1'b1, 16'h7FFF, 1'b0, 3'b011, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        bus.OUT_READY = 1'b1;
        CLR_STICKY = 1'b1;
        tick();
        CLR_STICKY = 1'b0;
        bus.OUT_READY = 1'b0;
        n_checks++; if (STICKY_V !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins got %0b want 1", STICKY_V); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1;
        bus.OUT_READY = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
`ifdef ALU_RES_STICKY_EN
        CLR_STICKY = 1'b0;
`endif
        test_reset();
        test_add_overflow();
        test_logic_flags();
        test_full_backpressure();
        test_simultaneous();
        test_random();
`ifdef ALU_RES_STICKY_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
